vending_ctrl_multi: RTL
=======================

# vending_ctrl_multi

Parametrised multi-product vending controller, successor to the single-product 20-cent soda machine. Accepts nickel/dime/quarter pulses, holds credit in nickel units, vends one of `NUM_ITEMS` products at per-item prices, returns change or refunds on cancel, and optionally tracks per-item stock. Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

## Interface
- `NUM_ITEMS`, 4: number of selectable products, 2 to 16.
- `CREDIT_W`, 5: credit, price and change width in nickel units (5 cents each).
- `PRICES`, {10,7,5,4}: packed `NUM_ITEMS*CREDIT_W` vector of prices in nickels. Item 0 is in the LSB slice. Every price must be ≥1.
- `STOCK_W`, 4: per-item stock counter width. Used only with `VEND_STOCK_EN`.
- `STOCK_INIT`, 8: stock loaded into every item at reset and on restock.
- `i_clk` input 1: clock. All state updates on the rising edge.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_nickle`, `i_dime`, `i_quarter` input 1 each: single-cycle coin pulses, worth 1, 2 and 5 nickels.
- `i_sel` input 1: product-select pulse.
- `i_sel_id` input `$clog2(NUM_ITEMS)`: product index, valid with `i_sel`.
- `i_cancel` input 1: refund request pulse.
- `i_restock` input 1: reload all stock counters. Effective only with `VEND_STOCK_EN`.
- `o_soda` output 1: one-cycle vend pulse.
- `o_vend_id` output `$clog2(NUM_ITEMS)`: item vended, valid with `o_soda`.
- `o_change` output `CREDIT_W`: change or refund amount in nickels, valid with `o_change_valid`.
- `o_change_valid` output 1: one-cycle change pulse.
- `o_credit` output `CREDIT_W`: current registered credit.
- `o_coin_reject` output 1: one-cycle pulse; a coin was not credited.
- `o_deny` output 1: one-cycle pulse; a selection was refused.
- `o_sold_out` output `NUM_ITEMS`: per-item stock-zero flags.
- `o_busy` output 1: high in VEND and CHANGE.

## Operation
FSM states: IDLE, COLLECT, VEND, CHANGE.

Cycle priority in IDLE/COLLECT: `i_cancel` > `i_sel` > coin. The coin is rejected in any cycle where cancel or select is taken.
- More than one coin input high in the same cycle: all rejected, `o_coin_reject` pulse.
- Coin that would push credit above `2**CREDIT_W-1`: rejected, credit unchanged.
- IDLE + accepted coin: credit = value, go to COLLECT.
- IDLE + select: `o_deny` pulse, since credit is 0.
- IDLE + cancel: ignored, no change pulse.
- COLLECT + coin: credit += value.
- COLLECT + select:
  - If `i_sel_id ≥ NUM_ITEMS`, sold out, or credit < price: `o_deny` pulse, stay in COLLECT, credit kept.
  - Otherwise: latch change = credit − price and id, go to VEND.
- COLLECT + cancel: latch change = credit, go to CHANGE.
- VEND (one cycle): `o_soda`=1 with `o_vend_id`; decrement that item's stock; credit cleared. Next state is CHANGE if change > 0, else IDLE.
- CHANGE (one cycle): `o_change_valid`=1 with `o_change`; credit cleared. Next state is IDLE.
- Coins, selects and cancels in VEND/CHANGE: coins get `o_coin_reject`; selects and cancels are dropped silently.
- `i_restock`: honoured only in IDLE. Other states ignore it.
- Reset asserted mid-transaction: FSM goes to IDLE and credit to 0. Stored credit is forfeited and no refund is generated.
- Reset values:
  - All pulse outputs 0.
  - `o_change`, `o_vend_id`, `o_credit` 0.
  - `o_busy` 0.
  - Stock = `STOCK_INIT`.
  - `o_sold_out` = all 1 iff `STOCK_INIT`==0.

## Timing
- Coin at edge t: `o_credit` updated from t.
- Select accepted at edge t: `o_soda` high in cycle t+1; `o_change_valid` high in t+2 if change > 0.
- Cancel at edge t: `o_change_valid` high in t+1.
- `o_deny` and `o_coin_reject` are registered and high in the cycle after the offending input.
- `o_sold_out[k]` updates in the cycle after the decrement that zeroes item k.
- At most one transaction every 2–3 cycles; no input queuing.

## Configuration
- `VEND_STOCK_EN` defined:
  - Per-item `STOCK_W` counters.
  - A decrement that would go below 0 is impossible, because the item is gated by sold-out.
  - `i_restock` reloads all counters.
  - Selecting a sold-out item gives `o_deny`.
- Undefined:
  - No counters.
  - `o_sold_out` tied to 0.
  - `i_restock` ignored.
  - Stock never limits vending.

## Structure
- Package `vending_pkg` holds:
  - the state enum;
  - coin value constants: NICKEL=1, DIME=2, QUARTER=5;
  - the default price vector.
- Sub-module `vend_stock`: counter bank producing sold-out flags. Instantiated only under `VEND_STOCK_EN`.

## Test plan
Defaults unless noted.
1. Dime, then quarter (credit 7), select item 0 → `o_soda`, id 0, then `o_change`=3; credit 0.
2. Nickel, select item 1 → `o_deny`, credit stays 1; cancel → `o_change_valid`, `o_change`=1.
3. Nickel and dime in the same cycle → `o_coin_reject`, credit 0, FSM stays in IDLE.
4. `STOCK_INIT`=2, buy item 0 twice with exact change (no change pulse) → `o_sold_out[0]`=1; third paid select → `o_deny`; restock in IDLE → flag clears.
5. Credit 30 (6 quarters), 7th quarter → `o_coin_reject`, credit stays 30; nickel → 31.
6. Credit 5, `i_rst_n` low mid-COLLECT → all outputs 0 immediately and no change pulse after release.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the multi-product vending controller.
//   state_e         : controller FSM states
//   NICKEL/DIME/... : coin values in nickel units
//   DEFAULT_PRICES  : default packed price vector (item 0 in the LSB slice)
package vending_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StVend,
    StChange
  } state_e;

  localparam logic [2:0] NICKEL  = 3'd1;
  localparam logic [2:0] DIME    = 3'd2;
  localparam logic [2:0] QUARTER = 3'd5;

  // Items 3..0 priced 10, 7, 5, 4 nickels.
  localparam logic [19:0] DEFAULT_PRICES = {5'd10, 5'd7, 5'd5, 5'd4};

endpackage

// File: rtl/vend_stock.sv
// Per-item stock counter bank with sold-out flags.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   restock_i     : reload every counter with STOCK_INIT
//   dec_i         : decrement the counter selected by dec_id_i
//   dec_id_i      : item index to decrement
//   sold_out_o    : per-item flag, high while that item's counter is zero
module vend_stock #(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 8,
  localparam int unsigned IdW       = $clog2(NUM_ITEMS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 restock_i,
  input  logic                 dec_i,
  input  logic [IdW-1:0]       dec_id_i,
  output logic [NUM_ITEMS-1:0] sold_out_o
);

  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_q, stock_d;

  always_comb begin
    stock_d = stock_q;
    if (restock_i) begin
      for (int unsigned k = 0; k < NUM_ITEMS; k++) begin
        stock_d[k] = STOCK_W'(STOCK_INIT);
      end
    end else if (dec_i) begin
      for (int unsigned k = 0; k < NUM_ITEMS; k++) begin
        // Never wraps: a zero counter cannot be selected for a vend.
        if (dec_id_i == IdW'(k) && stock_q[k] != '0) begin
          stock_d[k] = stock_q[k] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NUM_ITEMS; k++) begin
        stock_q[k] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      stock_q <= stock_d;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_ITEMS; k++) begin
      sold_out_o[k] = (stock_q[k] == '0);
    end
  end

endmodule

// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller. Collects nickel/dime/quarter pulses as credit
// (nickel units), vends one of NUM_ITEMS products at per-item prices, returns change,
// and refunds on cancel. Optional per-item stock tracking is built when the macro
// VEND_STOCK_EN is defined; otherwise o_sold_out is tied low and i_restock ignored.
// Ports:
//   i_clk, i_rst_n              : clock, asynchronous active-low reset
//   i_nickle/i_dime/i_quarter   : single-cycle coin pulses (1, 2, 5 nickels)
//   i_sel, i_sel_id             : product select pulse and index
//   i_cancel                    : refund request pulse
//   i_restock                   : reload stock counters (IDLE only)
//   o_soda, o_vend_id           : vend pulse and vended item
//   o_change, o_change_valid    : change/refund amount and its pulse
//   o_credit                    : registered credit
//   o_coin_reject, o_deny       : coin-not-credited and selection-refused pulses
//   o_sold_out                  : per-item stock-zero flags
//   o_busy                      : high while vending or paying change
module vending_ctrl_multi
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = 4,
  parameter int unsigned CREDIT_W  = 5,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = DEFAULT_PRICES,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 8,
  localparam int unsigned IdW       = $clog2(NUM_ITEMS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_nickle,
  input  logic                 i_dime,
  input  logic                 i_quarter,
  input  logic                 i_sel,
  input  logic [IdW-1:0]       i_sel_id,
  input  logic                 i_cancel,
  input  logic                 i_restock,
  output logic                 o_soda,
  output logic [IdW-1:0]       o_vend_id,
  output logic [CREDIT_W-1:0]  o_change,
  output logic                 o_change_valid,
  output logic [CREDIT_W-1:0]  o_credit,
  output logic                 o_coin_reject,
  output logic                 o_deny,
  output logic [NUM_ITEMS-1:0] o_sold_out,
  output logic                 o_busy
);

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [CREDIT_W-1:0]  change_q, change_d;
  logic [IdW-1:0]       id_q, id_d;
  logic                 soda_q, soda_d;
  logic                 change_valid_q, change_valid_d;
  logic                 coin_reject_q, coin_reject_d;
  logic                 deny_q, deny_d;
  logic                 stock_dec;
  logic [NUM_ITEMS-1:0] sold_out;

  // Coin decode
  logic                coin_any, coin_multi;
  logic [2:0]          coin_val;
  logic [CREDIT_W:0]   credit_sum;

  assign coin_any   = i_nickle | i_dime | i_quarter;
  assign coin_multi = (i_nickle & i_dime) | (i_nickle & i_quarter) | (i_dime & i_quarter);
  assign coin_val   = i_quarter ? QUARTER : i_dime ? DIME : i_nickle ? NICKEL : 3'd0;
  assign credit_sum = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_val);

  // Selection decode; the widened index keeps the range check meaningful for
  // non-power-of-two item counts.
  logic [IdW:0]        sel_ext;
  logic                sel_in_range, sel_sold, sel_ok;
  logic [CREDIT_W-1:0] sel_price;

  assign sel_ext      = {1'b0, i_sel_id};
  assign sel_in_range = sel_ext < (IdW + 1)'(NUM_ITEMS);

  always_comb begin
    sel_price = '0;
    sel_sold  = 1'b0;
    for (int unsigned k = 0; k < NUM_ITEMS; k++) begin
      if (sel_ext == (IdW + 1)'(k)) begin
        sel_price = PRICES[k*CREDIT_W +: CREDIT_W];
        sel_sold  = sold_out[k];
      end
    end
  end

  assign sel_ok = sel_in_range && !sel_sold && (credit_q >= sel_price);

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_d       = change_q;
    id_d           = id_q;
    soda_d         = 1'b0;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;
    deny_d         = 1'b0;
    stock_dec      = 1'b0;
    unique case (state_q)
      StIdle, StCollect: begin
        // Priority: cancel > select > coin; a coin alongside a taken cancel or
        // select is never credited.
        if (i_cancel) begin
          coin_reject_d = coin_any;
          if (state_q == StCollect) begin
            change_d = credit_q;
            state_d  = StChange;
          end
        end else if (i_sel) begin
          coin_reject_d = coin_any;
          if (state_q == StCollect && sel_ok) begin
            change_d = credit_q - sel_price;
            id_d     = i_sel_id;
            state_d  = StVend;
          end else begin
            deny_d = 1'b1;
          end
        end else if (coin_any) begin
          if (coin_multi || credit_sum[CREDIT_W]) begin
            coin_reject_d = 1'b1;
          end else begin
            credit_d = credit_sum[CREDIT_W-1:0];
            state_d  = StCollect;
          end
        end
      end
      StVend: begin
        soda_d        = 1'b1;
        stock_dec     = 1'b1;
        credit_d      = '0;
        coin_reject_d = coin_any;
        state_d       = (change_q != '0) ? StChange : StIdle;
      end
      StChange: begin
        change_valid_d = 1'b1;
        credit_d       = '0;
        coin_reject_d  = coin_any;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      change_q       <= '0;
      id_q           <= '0;
      soda_q         <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      deny_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      id_q           <= id_d;
      soda_q         <= soda_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      deny_q         <= deny_d;
    end
  end

`ifdef VEND_STOCK_EN
  vend_stock #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT)
  ) u_stock (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .restock_i  (i_restock && (state_q == StIdle)),
    .dec_i      (stock_dec),
    .dec_id_i   (id_q),
    .sold_out_o (sold_out)
  );
`else
  assign sold_out = '0;
  logic unused_stock;
  assign unused_stock = ^{i_restock, stock_dec, 32'(STOCK_W), 32'(STOCK_INIT)};
`endif

  assign o_soda         = soda_q;
  assign o_vend_id      = id_q;
  assign o_change       = change_q;
  assign o_change_valid = change_valid_q;
  assign o_credit       = credit_q;
  assign o_coin_reject  = coin_reject_q;
  assign o_deny         = deny_q;
  assign o_sold_out     = sold_out;
  assign o_busy         = (state_q == StVend) || (state_q == StChange);

endmodule
